// File: rtl/fetch_issue_queue.sv
// fetch_issue_queue: in-order instruction buffer between fetch and issue
// Ports:
//   clk_i, rst_i (async, active-high), flush_i (sync, discards all entries)
//   fetch_valid_i/fetch_ready_o with fetch_instr_i, fetch_pc_i, fetch_except_i
//   issue_valid_o/issue_ready_i with issue_instr_o, issue_pc_o, issue_except_o
//   count_o: number of stored entries
module fetch_issue_queue #(
    parameter int DEPTH = 4,
    parameter int ILEN  = 32,
    parameter int XLEN  = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     fetch_valid_i,
    output logic                     fetch_ready_o,
    input  logic [ILEN-1:0]          fetch_instr_i,
    input  logic [XLEN-1:0]          fetch_pc_i,
    input  logic                     fetch_except_i,
    output logic                     issue_valid_o,
    input  logic                     issue_ready_i,
    output logic [ILEN-1:0]          issue_instr_o,
    output logic [XLEN-1:0]          issue_pc_o,
    output logic                     issue_except_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = ILEN + XLEN + 1;

    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;
    logic          empty, full, push, pop;
    logic [EW-1:0] head;

    always_comb begin
        empty         = count == '0;
        full          = count == CW'(DEPTH);
        fetch_ready_o = !full && !flush_i && !rst_i;
        issue_valid_o = !empty && !flush_i;
        push          = fetch_valid_i && fetch_ready_o;
        pop           = issue_valid_o && issue_ready_i;
        head          = empty ? '0 : mem[rd_ptr];
        issue_instr_o  = head[EW-1:XLEN+1];
        issue_pc_o     = head[XLEN:1];
        issue_except_o = head[0];
        count_o        = count;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Storage carries no reset; only entries below count are ever observed.
    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= {fetch_instr_i, fetch_pc_i, fetch_except_i};
    end
endmodule

// File: tb/tb_fetch_issue_queue.sv
// tb_fetch_issue_queue: randomized check of fetch_issue_queue against a queue model
module tb_fetch_issue_queue;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        exc;
    } ent_t;

    logic        clk_i = 0, rst_i = 1, flush_i = 0;
    logic        fetch_valid_i = 0, fetch_ready_o, fetch_except_i = 0;
    logic [31:0] fetch_instr_i = 0, fetch_pc_i = 0;
    logic        issue_valid_o, issue_ready_i = 0, issue_except_o;
    logic [31:0] issue_instr_o, issue_pc_o;
    logic [2:0]  count_o;

    ent_t        q[$];
    int          checks = 0, errors = 0;
    logic [31:0] next_pc = 32'h1000;

    fetch_issue_queue #(.DEPTH(DEPTH), .ILEN(32), .XLEN(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .fetch_valid_i(fetch_valid_i), .fetch_ready_o(fetch_ready_o),
        .fetch_instr_i(fetch_instr_i), .fetch_pc_i(fetch_pc_i), .fetch_except_i(fetch_except_i),
        .issue_valid_o(issue_valid_o), .issue_ready_i(issue_ready_i),
        .issue_instr_o(issue_instr_o), .issue_pc_o(issue_pc_o), .issue_except_o(issue_except_o),
        .count_o(count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs(input logic fl, input logic rs);
        ent_t h;
        h = q.size() != 0 ? q[0] : '0;
        chk("fetch_ready", fetch_ready_o, q.size() < DEPTH && !fl && !rs);
        chk("issue_valid", issue_valid_o, q.size() != 0 && !fl);
        chk("count", count_o, q.size());
        chk("issue_instr", issue_instr_o, h.instr);
        chk("issue_pc", issue_pc_o, h.pc);
        chk("issue_except", issue_except_o, h.exc);
    endtask

    // One clock cycle: drive at negedge, check combinational outputs, then
    // advance the model with the handshake outcome at the rising edge.
    task automatic step(input logic v, input logic [31:0] ins, input logic ex,
                        input logic rdy, input logic fl, output logic pushed);
        logic pp;
        ent_t e;
        @(negedge clk_i);
        fetch_valid_i  = v;
        fetch_instr_i  = ins;
        fetch_pc_i     = next_pc;
        fetch_except_i = ex;
        issue_ready_i  = rdy;
        flush_i        = fl;
        #1;
        check_outputs(fl, 1'b0);
        pushed = v && !fl && q.size() < DEPTH;
        pp     = rdy && !fl && q.size() != 0;
        e      = '{instr: ins, pc: next_pc, exc: ex};
        @(posedge clk_i);
        if (fl) q.delete();
        else begin
            if (pp) void'(q.pop_front());
            if (pushed) q.push_back(e);
        end
        if (pushed) next_pc += 32'd4;
    endtask

    initial begin
        logic p;
        #2;
        check_outputs(1'b0, 1'b1);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 0;

        // single push, then head visible
        step(1, 32'h13, 0, 0, 0, p);
        step(0, 32'h0, 0, 0, 0, p);
        // fill to full and attempt an extra push
        repeat (5) step(1, $urandom, 1'($urandom), 0, 0, p);
        // full with both sides active: pop only
        step(1, $urandom, 0, 1, 0, p);
        // push and pop together at steady occupancy across the wrap
        step(0, 0, 0, 1, 0, p);
        repeat (10) step(1, $urandom, 1'($urandom), 1, 0, p);
        // flush with fetch_valid high, then a fresh push at 0x2000
        step(1, $urandom, 0, 1, 1, p);
        next_pc = 32'h2000;
        step(1, $urandom, 0, 0, 0, p);
        step(0, 0, 0, 0, 0, p);

        // randomized phases: fill-heavy, balanced, drain-heavy, flush-heavy
        for (int ph = 0; ph < 4; ph++) begin
            int pv, pr, pf;
            pv = ph == 0 ? 90 : ph == 1 ? 80 : ph == 2 ? 30 : 70;
            pr = ph == 0 ? 20 : ph == 1 ? 80 : ph == 2 ? 90 : 60;
            pf = ph == 3 ? 10 : 2;
            for (int i = 0; i < 150; i++)
                step($urandom_range(99) < pv, $urandom, 1'($urandom),
                     $urandom_range(99) < pr, $urandom_range(99) < pf, p);
        end

        // async reset between edges with two entries stored
        step(1, 32'h0, 0, 0, 1, p);
        step(1, $urandom, 0, 0, 0, p);
        step(1, $urandom, 0, 0, 0, p);
        @(negedge clk_i);
        fetch_valid_i = 0;
        issue_ready_i = 0;
        flush_i       = 0;
        #1;
        check_outputs(1'b0, 1'b0);
        #1;
        rst_i = 1;
        q.delete();
        #1;
        check_outputs(1'b0, 1'b1);
        @(posedge clk_i);
        #1;
        check_outputs(1'b0, 1'b1);
        @(negedge clk_i);
        rst_i = 0;
        repeat (20) step($urandom_range(1), $urandom, 1'($urandom), $urandom_range(1), 0, p);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
